// File: rtl/min_corr_search.sv
// min_corr_search: per-window best/second-best minimum tracker with a valid/ready result port
//   Ports: clk_i, reset_n_i (async, active low); start_i clears and opens a window;
//   in_valid_i/in_last_i/sum_corr_i/dx_i carry samples; out_valid_o/out_ready_i hand off
//   out_min_o, out_step_o, out_second_o, out_margin_o, out_unique_o, out_count_o; busy_o while scanning.
module min_corr_search #(
  parameter int CORR_W    = 9,
  parameter int DX_W      = 10,
  parameter int CNT_W     = 10,
  parameter int TIE_LAST  = 0,
  parameter int MARGIN_TH = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  input  logic [CORR_W-1:0] sum_corr_i,
  input  logic [DX_W-1:0]   dx_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CORR_W-1:0] out_min_o,
  output logic [DX_W-1:0]   out_step_o,
  output logic [CORR_W-1:0] out_second_o,
  output logic [CORR_W-1:0] out_margin_o,
  output logic              out_unique_o,
  output logic [CNT_W-1:0]  out_count_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t state_q, state_d;
  logic [CORR_W-1:0] best_q, best_d, second_q, second_d, margin_q, margin_d;
  logic [CORR_W-1:0] base_best, base_second;
  logic [DX_W-1:0]   step_q, step_d, base_step;
  logic [CNT_W-1:0]  count_q, count_d, base_count;
  logic              unique_q, unique_d, accept, better, done;
  always_comb begin
    // start clears first, so a sample arriving with start opens the new window
    base_best   = start_i ? '1 : best_q;
    base_second = start_i ? '1 : second_q;
    base_step   = start_i ? '0 : step_q;
    base_count  = start_i ? '0 : count_q;
    accept      = in_valid_i && (start_i || state_q == SCAN);
    done        = accept && in_last_i;
    better      = (TIE_LAST != 0) ? (sum_corr_i <= base_best) : (sum_corr_i < base_best);
    best_d      = (accept && better) ? sum_corr_i : base_best;
    step_d      = (accept && better) ? dx_i : base_step;
    // displaced best becomes second, keeping second >= best so margin cannot underflow
    second_d    = !accept ? base_second :
                  better ? base_best :
                  (sum_corr_i < base_second) ? sum_corr_i : base_second;
    count_d     = (accept && base_count != '1) ? base_count + CNT_W'(1) : base_count;
    margin_d    = done ? second_d - best_d : start_i ? '0 : margin_q;
    unique_d    = done ? (count_d > CNT_W'(1)) && (second_d - best_d >= CORR_W'(MARGIN_TH)) :
                  start_i ? 1'b0 : unique_q;
    state_d     = start_i ? (done ? HOLD : SCAN) :
                  (state_q == SCAN && done) ? HOLD :
                  (state_q == HOLD && out_ready_i) ? IDLE : state_q;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      best_q   <= '1;
      second_q <= '1;
      step_q   <= '0;
      count_q  <= '0;
      margin_q <= '0;
      unique_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      best_q   <= best_d;
      second_q <= second_d;
      step_q   <= step_d;
      count_q  <= count_d;
      margin_q <= margin_d;
      unique_q <= unique_d;
    end
  end
  assign out_valid_o  = state_q == HOLD;
  assign busy_o       = state_q == SCAN;
  assign out_min_o    = best_q;
  assign out_second_o = second_q;
  assign out_step_o   = step_q;
  assign out_count_o  = count_q;
  assign out_margin_o = margin_q;
  assign out_unique_o = unique_q;
endmodule

// File: tb/tb_min_corr_search.sv
// tb_min_corr_search: directed scoreboard bench for min_corr_search (default, TIE_LAST=1, CNT_W=2)
module tb_min_corr_search;
  logic clk = 0, reset_n = 0, start = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [8:0] sum_corr = 0;
  logic [9:0] dx = 0;
  logic       out_valid, out_unique, busy;
  logic [8:0] out_min, out_second, out_margin;
  logic [9:0] out_step, out_count;
  logic       t_valid, t_unique, t_busy;
  logic [8:0] t_min, t_second, t_margin;
  logic [9:0] t_step, t_count;
  logic       c_valid, c_unique, c_busy;
  logic [8:0] c_min, c_second, c_margin;
  logic [9:0] c_step;
  logic [1:0] c_count;
  int passed = 0, total = 0;
  typedef struct {int mn; int st; int sec; int mar; int uni; int cnt;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  min_corr_search dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .in_valid_i(in_valid), .in_last_i(in_last),
    .sum_corr_i(sum_corr), .dx_i(dx), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_min_o(out_min), .out_step_o(out_step), .out_second_o(out_second), .out_margin_o(out_margin),
    .out_unique_o(out_unique), .out_count_o(out_count), .busy_o(busy));
  min_corr_search #(.TIE_LAST(1)) u_tie (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .in_valid_i(in_valid), .in_last_i(in_last),
    .sum_corr_i(sum_corr), .dx_i(dx), .out_valid_o(t_valid), .out_ready_i(out_ready),
    .out_min_o(t_min), .out_step_o(t_step), .out_second_o(t_second), .out_margin_o(t_margin),
    .out_unique_o(t_unique), .out_count_o(t_count), .busy_o(t_busy));
  min_corr_search #(.CNT_W(2)) u_cnt (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .in_valid_i(in_valid), .in_last_i(in_last),
    .sum_corr_i(sum_corr), .dx_i(dx), .out_valid_o(c_valid), .out_ready_i(out_ready),
    .out_min_o(c_min), .out_step_o(c_step), .out_second_o(c_second), .out_margin_o(c_margin),
    .out_unique_o(c_unique), .out_count_o(c_count), .busy_o(c_busy));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic drive(input logic st, input logic v, input logic l, input int s, input int d);
    start = st; in_valid = v; in_last = l; sum_corr = 9'(s); dx = 10'(d);
    @(posedge clk); #1;
    start = 0; in_valid = 0; in_last = 0;
  endtask
  task automatic push(input int mn, input int st, input int sec, input int mar, input int uni, input int cnt);
    exp_t e;
    e = '{mn, st, sec, mar, uni, cnt};
    sb.push_back(e);
  endtask
  task automatic get_result(input string tag);
    exp_t e;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, ".valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".min"}, out_min, e.mn);
      chk({tag, ".step"}, out_step, e.st);
      chk({tag, ".second"}, out_second, e.sec);
      chk({tag, ".margin"}, out_margin, e.mar);
      chk({tag, ".unique"}, out_unique, e.uni);
      chk({tag, ".count"}, out_count, e.cnt);
      chk({tag, ".busy"}, busy, 0);
    end
  endtask
  task automatic handshake(input string tag);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, ".hs_valid"}, out_valid, 0);
    chk({tag, ".hs_busy"}, busy, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.min", out_min, 511);
    chk("rst.second", out_second, 511);
    chk("rst.step", out_step, 0);
    chk("rst.count", out_count, 0);
    chk("rst.margin", out_margin, 0);
    chk("rst.unique", out_unique, 0);
    chk("rst.valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    reset_n = 1;
    @(posedge clk); #1;
    // T1
    drive(1, 0, 0, 0, 0);
    chk("t1.busy", busy, 1);
    drive(0, 1, 0, 300, 0);
    drive(0, 1, 0, 120, 1);
    drive(0, 1, 0, 250, 2);
    drive(0, 1, 0, 90, 3);
    drive(0, 1, 1, 400, 4);
    push(90, 3, 120, 30, 1, 5);
    get_result("t1");
    handshake("t1");
    // T2: tie behaviour on both builds
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 50, 7);
    drive(0, 1, 1, 50, 8);
    push(50, 7, 50, 0, 0, 2);
    get_result("t2");
    chk("t2.tie_step", t_step, 8);
    chk("t2.tie_margin", t_margin, 0);
    handshake("t2");
    // T3: result held while out_ready stays low, samples ignored
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 10, 1);
    drive(0, 1, 1, 100, 2);
    push(10, 1, 100, 90, 1, 2);
    push(10, 1, 100, 90, 1, 2);
    get_result("t3a");
    for (int i = 0; i < 10; i++) drive(0, 1, i[0], 1, 9);
    get_result("t3b");
    handshake("t3");
    drive(0, 1, 1, 0, 9);
    chk("t3.idle_min", out_min, 10);
    chk("t3.idle_valid", out_valid, 0);
    // T4: restart mid-scan, then restart in HOLD
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 5, 10);
    drive(0, 1, 0, 6, 11);
    drive(0, 1, 0, 7, 12);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 200, 1);
    drive(0, 1, 1, 180, 2);
    push(180, 2, 200, 20, 1, 2);
    get_result("t4a");
    drive(1, 0, 0, 0, 0);
    chk("t4.drop_valid", out_valid, 0);
    chk("t4.drop_busy", busy, 1);
    drive(0, 1, 1, 70, 3);
    push(70, 3, 511, 441, 0, 1);
    get_result("t4b");
    handshake("t4");
    // T5: one-sample window in the start cycle
    drive(1, 1, 1, 40, 5);
    push(40, 5, 511, 471, 0, 1);
    get_result("t5");
    handshake("t5");
    // T6: count saturation on the narrow build
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, i == 5, 100 - 10 * i, i);
    push(50, 5, 60, 10, 0, 6);
    get_result("t6");
    chk("t6.sat_count", c_count, 3);
    chk("t6.sat_min", c_min, 50);
    handshake("t6");
    // async reset mid-scan and in HOLD
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 33, 4);
    drive(0, 1, 0, 22, 6);
    #2 reset_n = 0;
    #1;
    chk("t6.rs_min", out_min, 511);
    chk("t6.rs_count", out_count, 0);
    chk("t6.rs_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 30, 2);
    chk("t6.hold_valid", out_valid, 1);
    #2 reset_n = 0;
    #1;
    chk("t6.rh_valid", out_valid, 0);
    chk("t6.rh_min", out_min, 511);
    chk("t6.rh_step", out_step, 0);
    chk("t6.rh_second", out_second, 511);
    @(posedge clk); #1;
    reset_n = 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
